// File: rtl/mem_cmd_arbiter_pkg.sv
// Shared constants, class encoding and width helper for the memory command arbiter.
package mem_arb_pkg;

  localparam int unsigned MODE_WRFIRST  = 0;
  localparam int unsigned MODE_ALT      = 1;
  localparam int unsigned GUARD_DEFAULT = 5;

  typedef enum logic {
    CLS_RD = 1'b0,
    CLS_WR = 1'b1
  } cls_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_cmd_arbiter_if.sv
// Request/issue bus between the requesters, the DDR burst engines and the arbiter.
interface mem_cmd_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 768
);
  localparam int unsigned IDW_W = clog2((NUM_WR < 2) ? 2 : NUM_WR);
  localparam int unsigned IDW_R = clog2((NUM_RD < 2) ? 2 : NUM_RD);

  logic                       phy_init_done;
  logic                       r_busy;
  logic                       w_busy;
  logic [NUM_WR-1:0]          wr_req;
  logic [NUM_WR*ADDR_W-1:0]   wr_addr;
  logic [NUM_WR*DATA_W-1:0]   wr_data;
  logic [NUM_WR-1:0]          wr_pending;
  logic [NUM_WR-1:0]          wr_overflow;
  logic [NUM_RD-1:0]          rd_req;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD-1:0]          rd_pending;
  logic [NUM_RD-1:0]          rd_overflow;
  logic                       write_out;
  logic [ADDR_W-1:0]          w_address_out;
  logic [DATA_W-1:0]          w_data_out;
  logic [IDW_W-1:0]           w_grant_id;
  logic                       read_out;
  logic [ADDR_W-1:0]          r_address_out;
  logic [IDW_R-1:0]           r_grant_id;

  modport master (
    output phy_init_done, r_busy, w_busy, wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_pending, wr_overflow, rd_pending, rd_overflow,
    input  write_out, w_address_out, w_data_out, w_grant_id,
    input  read_out, r_address_out, r_grant_id
  );

  modport slave (
    input  phy_init_done, r_busy, w_busy, wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_pending, wr_overflow, rd_pending, rd_overflow,
    output write_out, w_address_out, w_data_out, w_grant_id,
    output read_out, r_address_out, r_grant_id
  );

endinterface

// File: rtl/mem_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int unsigned N   = 2,
  localparam int unsigned IDW = clog2((N < 2) ? 2 : N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic           found;
  logic [IDW-1:0] pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IDW'((32'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    any   = |req;
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/mem_cmd_arbiter.sv
// N-write / M-read command arbiter with one-entry slots, round-robin per class and a guard gap.
module mem_cmd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 768,
  parameter int unsigned GUARD  = GUARD_DEFAULT,
  parameter int unsigned MODE   = MODE_WRFIRST
) (
  input logic               clk,
  input logic               reset,
  mem_cmd_arbiter_if.slave  bus
);
  localparam int unsigned IDW_W = clog2((NUM_WR < 2) ? 2 : NUM_WR);
  localparam int unsigned IDW_R = clog2((NUM_RD < 2) ? 2 : NUM_RD);

  logic [NUM_WR-1:0] wr_full, wr_ovf, wr_cand, wr_onehot, wr_gnt;
  logic [NUM_RD-1:0] rd_full, rd_ovf, rd_cand, rd_onehot, rd_gnt;
  logic [ADDR_W-1:0] wr_slot_addr [NUM_WR];
  logic [DATA_W-1:0] wr_slot_data [NUM_WR];
  logic [ADDR_W-1:0] rd_slot_addr [NUM_RD];
  logic [IDW_W-1:0]  wr_ptr, wr_idx;
  logic [IDW_R-1:0]  rd_ptr, rd_idx;
  logic              wr_any, rd_any, wr_ok, rd_ok, do_wr, do_rd;
  logic [3:0]        guard;
  cls_e              last_cls;
  logic [ADDR_W-1:0] wr_sel_addr, rd_sel_addr;
  logic [DATA_W-1:0] wr_sel_data;

  // A request in its arrival cycle competes alongside held slots (bypass path).
  assign wr_cand = wr_full | bus.wr_req;
  assign rd_cand = rd_full | bus.rd_req;

  rr_pick #(.N(NUM_WR)) u_wr_pick (.req(wr_cand), .ptr(wr_ptr), .grant(wr_onehot), .idx(wr_idx), .any(wr_any));
  rr_pick #(.N(NUM_RD)) u_rd_pick (.req(rd_cand), .ptr(rd_ptr), .grant(rd_onehot), .idx(rd_idx), .any(rd_any));

  assign wr_ok = bus.phy_init_done && (guard == '0) && !bus.r_busy && wr_any;
  assign rd_ok = bus.phy_init_done && (guard == '0) && !bus.w_busy && rd_any;

  always_comb begin
    do_wr = 1'b0;
    do_rd = 1'b0;
    if (MODE == MODE_ALT && wr_ok && rd_ok) begin
      if (last_cls == CLS_WR) do_rd = 1'b1;
      else                    do_wr = 1'b1;
    end else if (wr_ok) begin
      do_wr = 1'b1;
    end else if (rd_ok) begin
      do_rd = 1'b1;
    end
  end

  assign wr_gnt = do_wr ? wr_onehot : '0;
  assign rd_gnt = do_rd ? rd_onehot : '0;

  assign wr_sel_addr = wr_full[wr_idx] ? wr_slot_addr[wr_idx] : bus.wr_addr[wr_idx*ADDR_W +: ADDR_W];
  assign wr_sel_data = wr_full[wr_idx] ? wr_slot_data[wr_idx] : bus.wr_data[wr_idx*DATA_W +: DATA_W];
  assign rd_sel_addr = rd_full[rd_idx] ? rd_slot_addr[rd_idx] : bus.rd_addr[rd_idx*ADDR_W +: ADDR_W];

  assign bus.wr_pending  = wr_full;
  assign bus.rd_pending  = rd_full;
  assign bus.wr_overflow = wr_ovf;
  assign bus.rd_overflow = rd_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_full           <= '0;
      rd_full           <= '0;
      wr_ovf            <= '0;
      rd_ovf            <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      guard             <= '0;
      last_cls          <= CLS_RD;
      bus.write_out     <= 1'b0;
      bus.w_address_out <= '0;
      bus.w_data_out    <= '0;
      bus.w_grant_id    <= '0;
      bus.read_out      <= 1'b0;
      bus.r_address_out <= '0;
      bus.r_grant_id    <= '0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        wr_slot_addr[i] <= '0;
        wr_slot_data[i] <= '0;
      end
      for (int unsigned i = 0; i < NUM_RD; i++) rd_slot_addr[i] <= '0;
    end else begin
      bus.write_out <= do_wr;
      bus.read_out  <= do_rd;
      // A slot granted this cycle frees up, so a simultaneous new request refills it.
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        wr_ovf[i] <= bus.wr_req[i] && wr_full[i] && !wr_gnt[i];
        if (wr_gnt[i])           wr_full[i] <= bus.wr_req[i] && wr_full[i];
        else if (bus.wr_req[i])  wr_full[i] <= 1'b1;
        if (bus.wr_req[i] && (!wr_full[i] || wr_gnt[i])) begin
          wr_slot_addr[i] <= bus.wr_addr[i*ADDR_W +: ADDR_W];
          wr_slot_data[i] <= bus.wr_data[i*DATA_W +: DATA_W];
        end
      end
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        rd_ovf[i] <= bus.rd_req[i] && rd_full[i] && !rd_gnt[i];
        if (rd_gnt[i])           rd_full[i] <= bus.rd_req[i] && rd_full[i];
        else if (bus.rd_req[i])  rd_full[i] <= 1'b1;
        if (bus.rd_req[i] && (!rd_full[i] || rd_gnt[i]))
          rd_slot_addr[i] <= bus.rd_addr[i*ADDR_W +: ADDR_W];
      end
      if (do_wr) begin
        bus.w_address_out <= wr_sel_addr;
        bus.w_data_out    <= wr_sel_data;
        bus.w_grant_id    <= wr_idx;
        wr_ptr            <= IDW_W'((32'(wr_idx) + 1) % NUM_WR);
        last_cls          <= CLS_WR;
      end
      if (do_rd) begin
        bus.r_address_out <= rd_sel_addr;
        bus.r_grant_id    <= rd_idx;
        rd_ptr            <= IDW_R'((32'(rd_idx) + 1) % NUM_RD);
        last_cls          <= CLS_RD;
      end
      if (do_wr || do_rd)  guard <= 4'(GUARD - 1);
      else if (guard != '0) guard <= guard - 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Scoreboard bench: two arbiters (write-first and alternating) share one stimulus stream.
module tb_mem_cmd_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned NW = 2, NR = 2, AW = 32, DW = 64, GD = 5;

  typedef struct {
    logic          is_wr;
    logic [7:0]    id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0, checks = 0, errors = 0;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_cmd_arbiter_if #(.NUM_WR(NW), .NUM_RD(NR), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_cmd_arbiter_if #(.NUM_WR(NW), .NUM_RD(NR), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus1.phy_init_done = bus0.phy_init_done;
  assign bus1.r_busy        = bus0.r_busy;
  assign bus1.w_busy        = bus0.w_busy;
  assign bus1.wr_req        = bus0.wr_req;
  assign bus1.wr_addr       = bus0.wr_addr;
  assign bus1.wr_data       = bus0.wr_data;
  assign bus1.rd_req        = bus0.rd_req;
  assign bus1.rd_addr       = bus0.rd_addr;

  mem_cmd_arbiter #(.NUM_WR(NW), .NUM_RD(NR), .ADDR_W(AW), .DATA_W(DW), .GUARD(GD), .MODE(MODE_WRFIRST))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_cmd_arbiter #(.NUM_WR(NW), .NUM_RD(NR), .ADDR_W(AW), .DATA_W(DW), .GUARD(GD), .MODE(MODE_ALT))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic w, input int id, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int c);
    exp_t e;
    e.is_wr = w; e.id = 8'(id); e.addr = a; e.data = d; e.cyc = c;
    return e;
  endfunction

  task automatic push_both(input exp_t e);
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic mon(input int inst, input logic wo, input logic ro, input logic [7:0] wid,
                     input logic [7:0] rid, input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                     input logic [DW-1:0] wd);
    exp_t e;
    int   n;
    if (wo || ro) begin
      n = (inst == 0) ? q0.size() : q1.size();
      if (n == 0) begin
        check($sformatf("unexpected_issue%0d", inst), DW'({wo, ro}), '0);
      end else begin
        if (inst == 0) e = q0.pop_front();
        else           e = q1.pop_front();
        check($sformatf("single_issue%0d", inst), DW'(wo & ro), '0);
        check($sformatf("class%0d", inst), DW'(wo), DW'(e.is_wr));
        check($sformatf("grant_id%0d", inst), DW'(e.is_wr ? wid : rid), DW'(e.id));
        check($sformatf("address%0d", inst), DW'(e.is_wr ? wa : ra), DW'(e.addr));
        check($sformatf("issue_cycle%0d", inst), DW'(cyc), DW'(e.cyc));
        if (e.is_wr) check($sformatf("wdata%0d", inst), wd, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon(0, bus0.write_out, bus0.read_out, 8'(bus0.w_grant_id), 8'(bus0.r_grant_id),
          bus0.w_address_out, bus0.r_address_out, bus0.w_data_out);
      mon(1, bus1.write_out, bus1.read_out, 8'(bus1.w_grant_id), 8'(bus1.r_grant_id),
          bus1.w_address_out, bus1.r_address_out, bus1.w_data_out);
    end
  end

  initial begin
    logic [AW-1:0] wa0, wa1, ra0, ra1;
    logic [DW-1:0] d0, d1, d2;
    int e;

    bus0.phy_init_done = 1'b1;
    bus0.r_busy = 1'b0;
    bus0.w_busy = 1'b0;
    bus0.wr_req = '0;
    bus0.rd_req = '0;
    bus0.wr_addr = '0;
    bus0.wr_data = '0;
    bus0.rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_write_out", DW'(bus0.write_out), '0);
    check("rst_read_out", DW'(bus0.read_out), '0);
    check("rst_wr_pending", DW'(bus0.wr_pending), '0);
    check("rst_rd_pending", DW'(bus0.rd_pending), '0);
    check("rst_overflow", DW'({bus0.wr_overflow, bus0.rd_overflow}), '0);
    check("rst_w_address", DW'(bus0.w_address_out), '0);
    check("rst_w_data", bus0.w_data_out, '0);
    check("rst_r_grant_id", DW'(bus1.r_grant_id), '0);
    reset = 1'b1;
    @(negedge clk);

    // All four requesters at once: write-first vs alternating order.
    wa0 = 32'h1000_0000; wa1 = 32'h1000_0040; ra0 = 32'h2000_0000; ra1 = 32'h2000_0080;
    d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
    bus0.wr_addr = {wa1, wa0}; bus0.wr_data = {d1, d0}; bus0.rd_addr = {ra1, ra0};
    bus0.wr_req = 2'b11; bus0.rd_req = 2'b11;
    e = cyc + 1;
    q0.push_back(mk(1, 0, wa0, d0, e));      q1.push_back(mk(1, 0, wa0, d0, e));
    q0.push_back(mk(1, 1, wa1, d1, e + 5));  q1.push_back(mk(0, 0, ra0, '0, e + 5));
    q0.push_back(mk(0, 0, ra0, '0, e + 10)); q1.push_back(mk(1, 1, wa1, d1, e + 10));
    q0.push_back(mk(0, 1, ra1, '0, e + 15)); q1.push_back(mk(0, 1, ra1, '0, e + 15));
    @(negedge clk);
    bus0.wr_req = '0; bus0.rd_req = '0;
    bus0.wr_addr = '1; bus0.wr_data = '1; bus0.rd_addr = '1;
    check("lat_write_out0", DW'(bus0.write_out), DW'(1));
    check("lat_write_out1", DW'(bus1.write_out), DW'(1));
    check("pend_wr_after_first", DW'(bus0.wr_pending), DW'(2'b10));
    check("pend_rd_after_first", DW'(bus0.rd_pending), DW'(2'b11));
    repeat (20) @(negedge clk);
    check("drain_all_four0", DW'(q0.size()), '0);
    check("drain_all_four1", DW'(q1.size()), '0);

    // Single write: one-cycle latency, one-cycle pulse, outputs held.
    wa0 = 32'h0000_1230; d0 = {$urandom, $urandom};
    bus0.wr_addr = {32'h0, wa0}; bus0.wr_data = {64'h0, d0}; bus0.wr_req = 2'b01;
    push_both(mk(1, 0, wa0, d0, cyc + 1));
    @(negedge clk);
    bus0.wr_req = '0;
    check("single_write_out", DW'(bus0.write_out), DW'(1));
    repeat (3) @(negedge clk);
    check("pulse_width", DW'(bus0.write_out), '0);
    check("hold_w_address", DW'(bus0.w_address_out), DW'(wa0));
    check("hold_w_data", bus1.w_data_out, d0);
    repeat (4) @(negedge clk);

    // r_busy holds a write without losing it.
    bus0.r_busy = 1'b1;
    wa1 = 32'h0000_7700; d1 = {$urandom, $urandom};
    bus0.wr_addr = {wa1, 32'h0}; bus0.wr_data = {d1, 64'h0}; bus0.wr_req = 2'b10;
    @(negedge clk);
    bus0.wr_req = '0;
    repeat (20) @(negedge clk);
    check("busy_pending", DW'(bus0.wr_pending), DW'(2'b10));
    check("busy_no_write", DW'(bus0.write_out), '0);
    bus0.r_busy = 1'b0;
    push_both(mk(1, 1, wa1, d1, cyc + 1));
    @(negedge clk);
    check("busy_release_pending", DW'(bus0.wr_pending), '0);
    repeat (6) @(negedge clk);

    // Overflow: second request to a full slot is dropped, first payload issues.
    bus0.phy_init_done = 1'b0;
    wa0 = 32'h0000_AA00; d0 = {$urandom, $urandom}; d2 = ~d0;
    bus0.wr_addr = {32'h0, wa0}; bus0.wr_data = {64'h0, d0}; bus0.wr_req = 2'b01;
    @(negedge clk);
    bus0.wr_addr = {32'h0, 32'h0000_BB00}; bus0.wr_data = {64'h0, d2};
    @(negedge clk);
    bus0.wr_req = '0;
    check("overflow_pulse0", DW'(bus0.wr_overflow), DW'(2'b01));
    check("overflow_pulse1", DW'(bus1.wr_overflow), DW'(2'b01));
    @(negedge clk);
    check("overflow_one_cycle", DW'(bus0.wr_overflow), '0);
    check("overflow_pending", DW'(bus0.wr_pending), DW'(2'b01));
    bus0.phy_init_done = 1'b1;
    push_both(mk(1, 0, wa0, d0, cyc + 1));
    @(negedge clk);
    repeat (6) @(negedge clk);

    // Reset while three slots pend and the guard is counting.
    ra1 = 32'h0000_C0C0;
    bus0.rd_addr = {ra1, 32'h0}; bus0.rd_req = 2'b10;
    push_both(mk(0, 1, ra1, '0, cyc + 1));
    @(negedge clk);
    bus0.rd_req = '0;
    bus0.phy_init_done = 1'b0;
    bus0.wr_req = 2'b11; bus0.rd_req = 2'b01;
    @(negedge clk);
    bus0.wr_req = '0; bus0.rd_req = '0;
    check("pre_reset_wr_pending", DW'(bus0.wr_pending), DW'(2'b11));
    check("pre_reset_rd_pending", DW'(bus0.rd_pending), DW'(2'b01));
    #2 reset = 1'b0;
    #1;
    check("async_wr_pending", DW'(bus0.wr_pending), '0);
    check("async_rd_pending", DW'(bus1.rd_pending), '0);
    check("async_r_address", DW'(bus0.r_address_out), '0);
    check("async_r_grant_id", DW'(bus0.r_grant_id), '0);
    @(negedge clk);
    reset = 1'b1;
    bus0.phy_init_done = 1'b1;
    repeat (10) @(negedge clk);
    ra0 = 32'h0000_D000; ra1 = 32'h0000_D080;
    bus0.rd_addr = {ra1, ra0}; bus0.rd_req = 2'b11;
    push_both(mk(0, 0, ra0, '0, cyc + 1));
    push_both(mk(0, 1, ra1, '0, cyc + 6));
    @(negedge clk);
    bus0.rd_req = '0;
    repeat (12) @(negedge clk);
    check("final_drain0", DW'(q0.size()), '0);
    check("final_drain1", DW'(q1.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
